capture_sequencer: RTL

Sequences sample capture for the internal logic analyzer. Contains its own programmable sample-rate divider (a strobe generator of the same kind the design already uses for periodic pulses) and drives write enables and addresses into the circular sample buffer. Arming, pre-trigger fill, trigger detection, post-trigger countdown and completion are all handled here. The block sits between the host/config registers and the sample RAM; the trigger comparator is external and supplies a 1-bit condition.

---
 rtl/capture_sequencer_if.sv | 28 ++
 rtl/capture_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/capture_sequencer_if.sv
// Host/trigger-side control inputs and buffer-side sample outputs of the capture sequencer.
interface capture_sequencer_if #(
   parameter int ADDR_W = 10,
   parameter int DIV_W  = 26
);
   logic              arm;
   logic              abort;
   logic [DIV_W-1:0]  div;
   logic [ADDR_W-1:0] pre_cnt;
   logic [ADDR_W-1:0] post_cnt;
   logic              trig_in;
   logic              sample_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] trig_addr;
   logic              armed;
   logic              triggered;
   logic              done;

   modport master (
      output arm, abort, div, pre_cnt, post_cnt, trig_in,
      input  sample_en, wr_addr, trig_addr, armed, triggered, done
   );

   modport slave (
      input  arm, abort, div, pre_cnt, post_cnt, trig_in,
      output sample_en, wr_addr, trig_addr, armed, triggered, done
   );
endinterface

// File: rtl/capture_sequencer.sv
// Logic-analyzer capture control: divides clk into sample ticks and walks arm/fill/trigger/post/done.
// All outputs registered; sample_en and wr_addr appear the cycle after a tick; abort beats arm and drops a pending sample.
module capture_sequencer #(
   parameter int ADDR_W = 10,
   parameter int DIV_W  = 26
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   capture_sequencer_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_POST, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [ADDR_W-1:0] pre_q, pre_d;
   logic [ADDR_W-1:0] post_q, post_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
   logic              sample_en_q, sample_en_d;
   logic              armed_q, armed_d;
   logic              triggered_q, triggered_d;
   logic              done_q, done_d;
   logic              active;
   logic              tick;
   logic [DIV_W-1:0]  div_last;

   // div of 0 and 1 both give a tick every cycle
   assign div_last = (div_q == '0) ? '0 : div_q - DIV_W'(1);
   assign active   = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
   assign tick     = active && (div_cnt_q == div_last);

   always_comb begin
      state_d     = state_q;
      div_cnt_d   = '0;
      div_d       = div_q;
      pre_d       = pre_q;
      post_d      = post_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      nxt_addr_d  = nxt_addr_q;
      wr_addr_d   = wr_addr_q;
      trig_addr_d = trig_addr_q;
      sample_en_d = 1'b0;

      if (bus.abort) begin
         state_d = S_IDLE;
      end else begin
         if (active) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
         end
         if (tick) begin
            sample_en_d = 1'b1;
            wr_addr_d   = nxt_addr_q;
            nxt_addr_d  = nxt_addr_q + ADDR_W'(1);
         end
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.arm) begin
                  div_d      = bus.div;
                  pre_d      = bus.pre_cnt;
                  post_d     = bus.post_cnt;
                  cnt_d      = '0;
                  nxt_addr_d = '0;
                  wr_addr_d  = '0;
                  state_d    = (bus.pre_cnt == '0) ? S_WAIT : S_FILL;
               end
            end
            S_FILL: begin
               if (tick) begin
                  cnt_d = cnt_q + ADDR_W'(1);
                  if (cnt_q + ADDR_W'(1) == pre_q) state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (tick && bus.trig_in) begin
                  trig_addr_d = nxt_addr_q;
                  rem_d       = post_q;
                  state_d     = (post_q == '0) ? S_DONE : S_POST;
               end
            end
            S_POST: begin
               if (tick) begin
                  rem_d = rem_q - ADDR_W'(1);
                  if (rem_q == ADDR_W'(1)) state_d = S_DONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      armed_d     = (state_d == S_FILL) || (state_d == S_WAIT);
      triggered_d = (state_d == S_POST) || (state_d == S_DONE);
      done_d      = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         div_cnt_q   <= '0;
         pre_q       <= '0;
         post_q      <= '0;
         cnt_q       <= '0;
         rem_q       <= '0;
         nxt_addr_q  <= '0;
         wr_addr_q   <= '0;
         trig_addr_q <= '0;
         sample_en_q <= 1'b0;
         armed_q     <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         div_cnt_q   <= div_cnt_d;
         pre_q       <= pre_d;
         post_q      <= post_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         nxt_addr_q  <= nxt_addr_d;
         wr_addr_q   <= wr_addr_d;
         trig_addr_q <= trig_addr_d;
         sample_en_q <= sample_en_d;
         armed_q     <= armed_d;
         triggered_q <= triggered_d;
         done_q      <= done_d;
      end
   end

   assign bus.sample_en = sample_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.trig_addr = trig_addr_q;
   assign bus.armed     = armed_q;
   assign bus.triggered = triggered_q;
   assign bus.done      = done_q;
endmodule
